// File: rtl/hamming_rx_sequencer.sv
// hamming_rx_sequencer: buffers UART codewords, drives the 7,4 Hamming decoder, pairs nibbles into bytes.
// Optional macro HAMMING_SEQ_DBLERR_EN: syndrome 3'b111 drops the pair and sets sticky dblerr.
`timescale 1ns/1ps
module hamming_rx_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       cw_in,
  input  logic             cw_valid,
  output logic             dec_ena,
  output logic [6:0]       dec_code,
  input  logic             dec_valid,
  input  logic [3:0]       dec_data,
  input  logic [2:0]       dec_syndrome,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             overflow,
  output logic             timeout,
`ifdef HAMMING_SEQ_DBLERR_EN
  output logic             dblerr,
`endif
  output logic [CNT_W-1:0] err_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [6:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [7:0] wait_q, wait_d;
  logic idx_q, idx_d;
  logic [3:0] lo_q, lo_d;
  logic dec_ena_q, dec_ena_d;
  logic [6:0] dec_code_q, dec_code_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic byte_valid_q, byte_valid_d;
  logic overflow_q, overflow_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic push, pop, full;
`ifdef HAMMING_SEQ_DBLERR_EN
  logic dblerr_q, dblerr_d;
  assign dblerr = dblerr_q;
`endif
  assign full = count_q == (PW+1)'(FIFO_DEPTH);
  always_comb begin
    pop = state_q == ISSUE;
    push = cw_valid && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    overflow_d = overflow_q || (cw_valid && !push);
    state_d = state_q;
    dec_ena_d = 1'b0;
    dec_code_d = dec_code_q;
    wait_d = wait_q;
    idx_d = idx_q;
    lo_d = lo_q;
    byte_out_d = byte_out_q;
    byte_valid_d = byte_valid_q;
    timeout_d = timeout_q;
    err_d = err_q;
`ifdef HAMMING_SEQ_DBLERR_EN
    dblerr_d = dblerr_q;
`endif
    case (state_q)
      IDLE: if (ena && count_q != '0) begin
        state_d = ISSUE;
        dec_ena_d = 1'b1;
        dec_code_d = mem_q[rd_ptr_q];
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d = '0;
      end
      WAIT: begin
        wait_d = wait_q + 8'd1;
`ifdef HAMMING_SEQ_DBLERR_EN
        if (dec_valid && dec_syndrome == 3'b111) begin
          idx_d = 1'b0;
          state_d = IDLE;
          dblerr_d = 1'b1;
        end else
`endif
        if (dec_valid) begin
          err_d = (dec_syndrome != 3'b000 && err_q != '1) ? err_q + 1'b1 : err_q;
          idx_d = !idx_q;
          lo_d = idx_q ? lo_q : dec_data;
          byte_out_d = idx_q ? {dec_data, lo_q} : byte_out_q;
          byte_valid_d = idx_q;
          state_d = idx_q ? OUT : IDLE;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          idx_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: if (byte_ready) begin
        byte_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      wait_q <= '0;
      idx_q <= 1'b0;
      lo_q <= '0;
      dec_ena_q <= 1'b0;
      dec_code_q <= '0;
      byte_out_q <= '0;
      byte_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q <= 1'b0;
      err_q <= '0;
`ifdef HAMMING_SEQ_DBLERR_EN
      dblerr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      wait_q <= wait_d;
      idx_q <= idx_d;
      lo_q <= lo_d;
      dec_ena_q <= dec_ena_d;
      dec_code_q <= dec_code_d;
      byte_out_q <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      overflow_q <= overflow_d;
      timeout_q <= timeout_d;
      err_q <= err_d;
`ifdef HAMMING_SEQ_DBLERR_EN
      dblerr_q <= dblerr_d;
`endif
    end
  end
  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cw_in;
  end
  assign dec_ena = dec_ena_q;
  assign dec_code = dec_code_q;
  assign byte_out = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign overflow = overflow_q;
  assign timeout = timeout_q;
  assign err_count = err_q;
  assign busy = state_q != IDLE || count_q != '0;
endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// tb_hamming_rx_sequencer: directed and randomized checks against a nibble-pairing reference model.
// Honours HAMMING_SEQ_DBLERR_EN when the design is built with it.
`timescale 1ns/1ps
module tb_hamming_rx_sequencer;
  localparam int TMO = 15;
  typedef struct {logic [3:0] d; logic [2:0] s; int dly;} rsp_t;
  logic clk = 0, rst_n = 1, ena = 0, cw_valid = 0, dec_valid = 0, byte_ready = 0;
  logic [6:0] cw_in = 0;
  logic [3:0] dec_data = 0;
  logic [2:0] dec_syndrome = 0;
  logic dec_ena, byte_valid, busy, overflow, timeout;
  logic [6:0] dec_code;
  logic [7:0] byte_out, err_count;
`ifdef HAMMING_SEQ_DBLERR_EN
  logic dblerr;
`endif
  int checks = 0, passed = 0, ena_pulses = 0;
  rsp_t rsp_q[$];
  logic [6:0] issued_q[$];
  logic [7:0] obs_q[$];

  always #5 clk = ~clk;

  hamming_rx_sequencer #(.FIFO_DEPTH(2), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cw_in(cw_in), .cw_valid(cw_valid),
    .dec_ena(dec_ena), .dec_code(dec_code), .dec_valid(dec_valid), .dec_data(dec_data),
    .dec_syndrome(dec_syndrome), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .overflow(overflow), .timeout(timeout),
`ifdef HAMMING_SEQ_DBLERR_EN
    .dblerr(dblerr),
`endif
    .err_count(err_count));

  // Decoder stand-in: answers each enable with the next queued result after dly cycles (0 = silent).
  initial begin : responder
    rsp_t r;
    forever begin
      @(posedge clk); #1;
      if (rst_n && dec_ena) begin
        ena_pulses++;
        issued_q.push_back(dec_code);
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          if (r.dly > 0) begin
            repeat (r.dly) @(posedge clk);
            #1 dec_valid = 1; dec_data = r.d; dec_syndrome = r.s;
            @(posedge clk);
            #1 dec_valid = 0;
          end
        end
      end
    end
  end

  initial begin : collector
    forever begin
      @(negedge clk);
      if (rst_n && byte_valid && byte_ready) obs_q.push_back(byte_out);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 0; ena = 0; cw_valid = 0; byte_ready = 0; dec_valid = 0;
    rsp_q.delete(); issued_q.delete(); obs_q.delete(); ena_pulses = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic push(input logic [6:0] c);
    cw_in = c; cw_valid = 1;
    @(posedge clk);
    #1 cw_valid = 0;
  endtask

  task automatic settle(output bit ok);
    int n;
    n = 0;
    while ((busy || byte_valid) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    ok = !(busy || byte_valid);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++; if ({dec_ena, byte_valid, busy, overflow, timeout} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {dec_ena, byte_valid, busy, overflow, timeout}); else passed++;
    checks++; if (dec_code !== 7'h00) $display("FAIL reset_dec_code: got %h want 00", dec_code); else passed++;
    checks++; if (byte_out !== 8'h00) $display("FAIL reset_byte_out: got %h want 00", byte_out); else passed++;
    checks++; if (err_count !== 8'h00) $display("FAIL reset_err_count: got %0d want 0", err_count); else passed++;
`ifdef HAMMING_SEQ_DBLERR_EN
    checks++; if (dblerr !== 1'b0) $display("FAIL reset_dblerr: got %b want 0", dblerr); else passed++;
`endif
    do_reset();
  endtask

  task automatic test_basic();
    int n;
    do_reset(); ena = 1; byte_ready = 0;
    rsp_q.push_back('{4'h3, 3'd0, 3}); rsp_q.push_back('{4'hC, 3'd0, 3});
    push(7'h55); push(7'h2A);
    n = 0;
    while (!byte_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (byte_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", byte_valid); else passed++;
    checks++; if (byte_out !== 8'hC3) $display("FAIL basic_byte: got %h want c3", byte_out); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL basic_err: got %0d want 0", err_count); else passed++;
    checks++; if (issued_q.size() != 2 || issued_q[0] !== 7'h55 || issued_q[1] !== 7'h2A) $display("FAIL basic_issued: got %0d codes want 55,2a", issued_q.size()); else passed++;
    byte_ready = 1;
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_accept: got valid=%b busy=%b want 0 0", byte_valid, busy); else passed++;
    repeat (4) @(posedge clk); #1;
    checks++; if (ena_pulses != 2) $display("FAIL basic_pulses: got %0d want 2", ena_pulses); else passed++;
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'hC3) $display("FAIL basic_obs: got %0d bytes want 1 (c3)", obs_q.size()); else passed++;
  endtask

  task automatic test_syndrome();
    bit ok;
    do_reset(); ena = 1; byte_ready = 1;
    rsp_q.push_back('{4'h3, 3'd0, 3}); rsp_q.push_back('{4'hC, 3'b101, 3});
    push(7'h55); push(7'h2A);
    settle(ok);
    checks++; if (!ok) $display("FAIL syn_settle: got busy want idle"); else passed++;
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'hC3) $display("FAIL syn_byte: got %0d bytes want 1 (c3)", obs_q.size()); else passed++;
    checks++; if (err_count !== 8'd1) $display("FAIL syn_err: got %0d want 1", err_count); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    do_reset(); ena = 1; byte_ready = 0;
    rsp_q.push_back('{4'h5, 3'd0, 2}); rsp_q.push_back('{4'hA, 3'd0, 2});
    rsp_q.push_back('{4'h1, 3'd0, 2}); rsp_q.push_back('{4'h2, 3'd0, 2});
    push(7'h11); push(7'h22);
    n = 0;
    while (!byte_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (byte_out !== 8'hA5 || byte_valid !== 1'b1) $display("FAIL bp_first: got %h/%b want a5/1", byte_out, byte_valid); else passed++;
    push(7'h33); push(7'h44);
    checks++; if (overflow !== 1'b0) $display("FAIL bp_no_overflow: got %b want 0", overflow); else passed++;
    push(7'h55);
    checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", overflow); else passed++;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++; if (byte_out !== 8'hA5 || byte_valid !== 1'b1) $display("FAIL bp_stable%0d: got %h/%b want a5/1", i, byte_out, byte_valid); else passed++;
    end
    checks++; if (ena_pulses != 2) $display("FAIL bp_no_issue: got %0d want 2", ena_pulses); else passed++;
    byte_ready = 1;
    settle(ok);
    checks++; if (!ok) $display("FAIL bp_settle: got busy want idle"); else passed++;
    checks++; if (obs_q.size() != 2 || obs_q[0] !== 8'hA5 || obs_q[1] !== 8'h21) $display("FAIL bp_bytes: got %0d bytes want a5,21", obs_q.size()); else passed++;
    checks++; if (issued_q.size() != 4 || issued_q[2] !== 7'h33 || issued_q[3] !== 7'h44) $display("FAIL bp_issued: got %0d codes want 11,22,33,44", issued_q.size()); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overflow); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset(); ena = 1; byte_ready = 1;
    rsp_q.push_back('{4'h6, 3'd0, TMO}); rsp_q.push_back('{4'h9, 3'd0, TMO});
    push(7'h01); push(7'h02);
    settle(ok);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h96 || timeout !== 1'b0) $display("FAIL to_edge: got %0d bytes timeout=%b want 96 and 0", obs_q.size(), timeout); else passed++;
    do_reset(); ena = 1; byte_ready = 1;
    rsp_q.push_back('{4'hA, 3'd0, 1}); rsp_q.push_back('{4'h0, 3'd0, 0});
    rsp_q.push_back('{4'h3, 3'd0, 1}); rsp_q.push_back('{4'h4, 3'd0, 1});
    push(7'h10); settle(ok);
    push(7'h20);
    n = 0;
    while (!dec_ena && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (dec_ena !== 1'b1) $display("FAIL to_issue: got %b want 1", dec_ena); else passed++;
    repeat (TMO) @(posedge clk); #1;
    checks++; if (timeout !== 1'b0) $display("FAIL to_early: got %b want 0", timeout); else passed++;
    @(posedge clk); #1;
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) $display("FAIL to_fire: got timeout=%b busy=%b want 1 0", timeout, busy); else passed++;
    push(7'h30); push(7'h40);
    settle(ok);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h43) $display("FAIL to_resume: got %0d bytes want 1 (43)", obs_q.size()); else passed++;
  endtask

  task automatic test_ena();
    do_reset(); ena = 0; byte_ready = 1;
    rsp_q.push_back('{4'h7, 3'd0, 0});
    push(7'h5A); push(7'h3C);
    repeat (6) @(posedge clk); #1;
    checks++; if (ena_pulses != 0 || busy !== 1'b1) $display("FAIL ena_hold: got pulses=%0d busy=%b want 0 1", ena_pulses, busy); else passed++;
    ena = 1;
    @(posedge clk); #1;
    checks++; if (dec_ena !== 1'b1 || dec_code !== 7'h5A) $display("FAIL ena_resume: got %b/%h want 1/5a", dec_ena, dec_code); else passed++;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (dec_code !== 7'h00 || busy !== 1'b0 || dec_ena !== 1'b0) $display("FAIL ena_async_rst: got code=%h busy=%b want 00 0", dec_code, busy); else passed++;
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] c;
    logic [3:0] d, lo;
    logic [2:0] s;
    logic [7:0] exp_q[$];
    logic [6:0] codes[$];
    int dly, errs;
    bit lo_v, to_exp, dbl_exp, ok, all_ok, same;
    do_reset(); ena = 1; byte_ready = 1;
    lo = 0; lo_v = 0; errs = 0; to_exp = 0; dbl_exp = 0; all_ok = 1;
    for (int i = 0; i < 40; i++) begin
      c = 7'($urandom_range(0, 127));
      d = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
      if (dly == 0) begin
        to_exp = 1; lo_v = 0;
      end
`ifdef HAMMING_SEQ_DBLERR_EN
      else if (s == 3'b111) begin
        dbl_exp = 1; lo_v = 0;
      end
`endif
      else begin
        if (s != 0 && errs < 255) errs++;
        if (lo_v) exp_q.push_back({d, lo});
        else lo = d;
        lo_v = !lo_v;
      end
      rsp_q.push_back('{d, s, dly});
      codes.push_back(c);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      push(c);
      settle(ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) $display("FAIL rand_settle: got busy want idle"); else passed++;
    same = obs_q.size() == exp_q.size();
    for (int i = 0; i < exp_q.size() && same; i++) same = obs_q[i] === exp_q[i];
    checks++; if (!same) $display("FAIL rand_bytes: got %0d bytes want %0d (or content differs)", obs_q.size(), exp_q.size()); else passed++;
    same = issued_q.size() == codes.size();
    for (int i = 0; i < codes.size() && same; i++) same = issued_q[i] === codes[i];
    checks++; if (!same) $display("FAIL rand_issued: got %0d codes want %0d (or order differs)", issued_q.size(), codes.size()); else passed++;
    checks++; if (err_count !== 8'(errs)) $display("FAIL rand_err: got %0d want %0d", err_count, errs); else passed++;
    checks++; if (timeout !== to_exp) $display("FAIL rand_timeout: got %b want %b", timeout, to_exp); else passed++;
`ifdef HAMMING_SEQ_DBLERR_EN
    checks++; if (dblerr !== dbl_exp) $display("FAIL rand_dblerr: got %b want %b", dblerr, dbl_exp); else passed++;
`endif
  endtask

  task automatic test_saturate();
    bit ok, all_ok;
    do_reset(); ena = 1; byte_ready = 1; all_ok = 1;
    for (int i = 0; i < 260; i++) begin
      rsp_q.push_back('{4'(i), 3'd1, 1});
      push(7'(i));
      settle(ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) $display("FAIL sat_settle: got busy want idle"); else passed++;
    checks++; if (err_count !== 8'hFF) $display("FAIL sat_err: got %0d want 255", err_count); else passed++;
    checks++; if (obs_q.size() != 130) $display("FAIL sat_bytes: got %0d want 130", obs_q.size()); else passed++;
  endtask

`ifdef HAMMING_SEQ_DBLERR_EN
  task automatic test_dblerr();
    bit ok;
    do_reset(); ena = 1; byte_ready = 1;
    rsp_q.push_back('{4'h3, 3'd0, 1}); rsp_q.push_back('{4'hC, 3'b111, 1});
    rsp_q.push_back('{4'h5, 3'd0, 1}); rsp_q.push_back('{4'h6, 3'd0, 1});
    push(7'h01); settle(ok);
    push(7'h02); settle(ok);
    checks++; if (obs_q.size() != 0 || dblerr !== 1'b1 || err_count !== 8'd0) $display("FAIL dbl_drop: got bytes=%0d dblerr=%b err=%0d want 0 1 0", obs_q.size(), dblerr, err_count); else passed++;
    push(7'h03); settle(ok);
    push(7'h04); settle(ok);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h65) $display("FAIL dbl_resume: got %0d bytes want 1 (65)", obs_q.size()); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_syndrome();
    test_backpressure();
    test_timeout();
    test_ena();
    test_random();
    test_saturate();
`ifdef HAMMING_SEQ_DBLERR_EN
    test_dblerr();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hamming_rx_sequencer.md
Name: hamming_rx_sequencer

Overview:
Controller between the UART receiver and the 7,4 Hamming decoder. It buffers received 7-bit codewords, issues each one to the decoder with a single-cycle enable, and waits for the decoder's valid with a timeout. It pairs the decoded nibbles into bytes, low nibble first, and presents each byte on a valid/ready handshake. It also reports FIFO overflow, decoder timeout and a corrected-error count.

Parameters:
FIFO_DEPTH, 2, codeword buffer entries; power of 2, >=2
TIMEOUT, 15, max cycles in WAIT before abandoning a codeword (1..255)
CNT_W, 8, width of corrected-error counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low blocks new issues
cw_in  input  7  codeword from UART receiver
cw_valid  input  1  one-cycle strobe, cw_in valid
dec_ena  output  1  one-cycle decoder enable
dec_code  output  7  codeword presented to decoder
dec_valid  input  1  decoder result valid
dec_data  input  4  decoded nibble
dec_syndrome  input  3  decoder syndrome, nonzero = single-bit corrected
byte_out  output  8  assembled byte {hi_nibble, lo_nibble}
byte_valid  output  1  byte_out valid, held until accepted
byte_ready  input  1  consumer accepts when byte_valid & byte_ready
busy  output  1  FSM not in IDLE, or FIFO non-empty
overflow  output  1  sticky: codeword dropped, FIFO full
timeout  output  1  sticky: decoder failed to respond
err_count  output  CNT_W  corrected-error count, saturating

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, nibble index=0, all outputs 0 (dec_code=0, byte_out=0, err_count=0).
- FIFO push: cw_valid=1 and not full. Push while full drops the word and sets overflow.
- Push while full is accepted if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. A full/empty count register disambiguates.
- FSM states IDLE, ISSUE, WAIT, OUT.
- IDLE -> ISSUE: when ena=1 and the FIFO is non-empty.
- ISSUE: dec_code is registered from the FIFO head, dec_ena=1 for exactly this cycle, and the head is popped. Next state is WAIT with the wait counter cleared. dec_code holds its value until the next ISSUE.
- WAIT: the wait counter increments each cycle.
- WAIT with dec_valid=1: capture dec_data.
  - Index 0: store as low nibble, index=1, go to IDLE.
  - Index 1: byte_out={dec_data, lo}, byte_valid=1, index=0, go to OUT.
- WAIT on the same dec_valid cycle: if dec_syndrome!=0, err_count increments, saturating at all-ones.
- WAIT when the counter reaches TIMEOUT without dec_valid: set timeout, discard any stored low nibble (index=0), go to IDLE.
- WAIT if dec_valid and the counter reaching TIMEOUT coincide: dec_valid wins.
- dec_valid outside WAIT is ignored.
- OUT: byte_valid stays high and byte_out stays stable until byte_ready=1. That cycle clears byte_valid and returns to IDLE. The FIFO keeps accepting pushes during OUT.
- Latency: cw_valid to dec_ena is 2 cycles minimum (push, then IDLE->ISSUE).
- ena=0: no new ISSUE. An in-flight WAIT/OUT completes normally. The FIFO still accepts pushes.
- overflow and timeout clear only on reset.

Optional Feature:
Macro HAMMING_SEQ_DBLERR_EN.
- Defined:
  - A codeword whose dec_syndrome equals 3'b111 is treated as uncorrectable. The nibble is discarded, the stored low nibble is also discarded (index=0), and the FSM returns to IDLE.
  - err_count does not increment for this codeword.
  - An extra sticky output dblerr (1 bit, reset 0) is set.
- Not defined: syndrome 3'b111 is treated like any other nonzero syndrome (counted, nibble used). The dblerr port is absent.

Test Plan:
- Reset, then push cw 0x55 and 0x2A; decoder model answers after 3 cycles with data 4'h3 then 4'hC, syndrome 0 -> byte_out=0xC3, byte_valid=1, err_count=0, exactly two dec_ena pulses.
- Same two words, second result carries syndrome 3'b101 -> byte_out formed normally, err_count=1.
- Hold byte_ready=0 for 10 cycles while pushing 3 more codewords with FIFO_DEPTH=2 -> byte_out stable throughout, third push sets overflow=1, the two buffered words are issued after byte_ready=1.
- Decoder never asserts dec_valid -> timeout=1 exactly TIMEOUT cycles after entering WAIT, FSM returns to IDLE, next word pair assembles a correct byte.
- ena=0 with words buffered -> no dec_ena. Raising ena resumes issue on the next cycle. Pulsing rst_n=0 mid-WAIT clears all outputs asynchronously.
- With HAMMING_SEQ_DBLERR_EN: syndrome 3'b111 on the second nibble -> no byte_valid, dblerr=1, err_count unchanged.
